// File: rtl/scan_decoder_n.sv
`timescale 1ns/1ps
// scan_decoder_n: registered 2^SEL_W active-low one-hot decoder with auto-scan.
// Define SCAN_BLANK_EN to insert one all-off cycle between scanned lines.
module scan_decoder_n #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [DWELL_W-1:0]    dwell,
   output logic [0:(1<<SEL_W)-1] D_n,
   output logic [SEL_W-1:0]      cur_sel,
   output logic                  wrap
);

   localparam int NOUT = 1 << SEL_W;

   typedef enum logic [1:0] {
      IDLE,
      DIRECT,
`ifdef SCAN_BLANK_EN
      SCAN,
      BLANK
`else
      SCAN
`endif
   } state_t;

   state_t             state;
   logic [SEL_W-1:0]   idx;
   logic [DWELL_W-1:0] cnt;
   logic [SEL_W-1:0]   nxt_idx;

   assign nxt_idx = idx + SEL_W'(1);

   function automatic logic [0:NOUT-1] onehot_n(input logic [SEL_W-1:0] s);
      logic [0:NOUT-1] r;
      r    = '1;
      r[s] = 1'b0;
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         D_n     <= '1;
         cur_sel <= '0;
         wrap    <= 1'b0;
      end else if (enable_n) begin
         // disable wins over mode changes and dwell expiry
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         D_n   <= '1;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         unique case (state)
            IDLE, DIRECT: begin
               if (mode) begin
                  state   <= SCAN;
                  idx     <= '0;
                  cnt     <= dwell;
                  D_n     <= onehot_n('0);
                  cur_sel <= '0;
               end else begin
                  state   <= DIRECT;
                  D_n     <= onehot_n(sel);
                  cur_sel <= sel;
               end
            end
            SCAN: begin
               if (!mode) begin
                  state   <= DIRECT;
                  D_n     <= onehot_n(sel);
                  cur_sel <= sel;
               end else if (cnt == '0) begin
`ifdef SCAN_BLANK_EN
                  state <= BLANK;
                  D_n   <= '1;
`else
                  idx     <= nxt_idx;
                  cnt     <= dwell;
                  D_n     <= onehot_n(nxt_idx);
                  cur_sel <= nxt_idx;
                  wrap    <= (nxt_idx == '0);
`endif
               end else begin
                  cnt <= cnt - DWELL_W'(1);
               end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
               if (!mode) begin
                  state   <= DIRECT;
                  D_n     <= onehot_n(sel);
                  cur_sel <= sel;
               end else begin
                  state   <= SCAN;
                  idx     <= nxt_idx;
                  cnt     <= dwell;
                  D_n     <= onehot_n(nxt_idx);
                  cur_sel <= nxt_idx;
                  wrap    <= (nxt_idx == '0);
               end
            end
`endif
            default: begin
               state <= IDLE;
               D_n   <= '1;
            end
         endcase
      end
   end

endmodule
